// File: rtl/decoder_iter_ctrl_pkg.sv
// Shared definitions for the min-sum iteration scheduler: state encodings,
// reset polarity and default iteration parameters.
package decoder_iter_ctrl_pkg;

  // Scheduler state encodings
  localparam logic [2:0] StateIdle    = 3'd0;
  localparam logic [2:0] StateVnRun   = 3'd1;
  localparam logic [2:0] StateCnRun   = 3'd2;
  localparam logic [2:0] StateOutRun  = 3'd3;
  localparam logic [2:0] StateOutHold = 3'd4;

  typedef enum logic [2:0] {
    StIdle    = StateIdle,
    StVnRun   = StateVnRun,
    StCnRun   = StateCnRun,
    StOutRun  = StateOutRun,
    StOutHold = StateOutHold
  } state_e;

  // Level of rst that forces the reset state
  localparam logic ResetVal = 1'b1;

  localparam int unsigned NIterDefault = 5;
  localparam int unsigned IterWDefault = 4;

endpackage

// File: rtl/decoder_iter_ctrl_stage_handshake.sv
// Start/done handshake for one processing layer: turns an enter strobe into a
// registered one-cycle start pulse, then arms and qualifies the done pulse.
// A done coincident with the start pulse, or outside the armed window, is dropped.
module decoder_iter_ctrl_stage_handshake
  import decoder_iter_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enter,
  input  logic clear,
  input  logic done,
  output logic start,
  output logic done_ok
);

  logic start_q;
  logic armed_q, armed_d;

  assign start   = start_q;
  assign done_ok = armed_q & done;

  // Arm window opens the cycle after the start pulse and closes on done or abort
  always_comb begin
    armed_d = armed_q;
    if (clear) begin
      armed_d = 1'b0;
    end else if (start_q) begin
      armed_d = 1'b1;
    end else if (done_ok) begin
      armed_d = 1'b0;
    end
  end

  // Start pulse and arm flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst == ResetVal) begin
      start_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      start_q <= enter & ~clear;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/decoder_iter_ctrl.sv
// Iteration scheduler for the min-sum decoder core. Takes a loaded frame,
// runs N_ITER VN->CN rounds, triggers the output layer and holds dec_valid
// until downstream accepts. Optional early termination on a satisfied
// syndrome is enabled by defining DECODER_EARLY_TERM_EN.
module decoder_iter_ctrl
  import decoder_iter_ctrl_pkg::*;
#(
  parameter int unsigned N_ITER = NIterDefault,
  parameter int unsigned ITER_W = IterWDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              vn_start,
  input  logic              vn_done,
  output logic              cn_start,
  input  logic              cn_done,
  input  logic              syndrome_ok,
  output logic              out_start,
  input  logic              out_done,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              early_term
);

  if ((N_ITER < 1) || (N_ITER >= (1 << ITER_W))) begin : g_param_check
    $error("decoder_iter_ctrl: N_ITER must lie in 1..2**ITER_W-1");
  end

  localparam logic [ITER_W-1:0] NIterCnt = ITER_W'(N_ITER);

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d, iter_inc;
  logic              et_q, et_d;
  logic              in_ready_q, dec_valid_q;
  logic              vn_enter, cn_enter, out_enter;
  logic              vn_ok, cn_ok, out_ok;
  logic              term_now;

`ifdef DECODER_EARLY_TERM_EN
  assign term_now = syndrome_ok;
`else
  logic unused_syndrome_ok;
  assign unused_syndrome_ok = syndrome_ok;
  assign term_now           = 1'b0;
`endif

  assign iter_inc   = iter_q + ITER_W'(1);
  assign in_ready   = in_ready_q;
  assign dec_valid  = dec_valid_q;
  assign iter_cnt   = iter_q;
  assign early_term = et_q;

  decoder_iter_ctrl_stage_handshake u_vn_hs (
    .clk     (clk),
    .rst     (rst),
    .enter   (vn_enter),
    .clear   (flush),
    .done    (vn_done),
    .start   (vn_start),
    .done_ok (vn_ok)
  );

  decoder_iter_ctrl_stage_handshake u_cn_hs (
    .clk     (clk),
    .rst     (rst),
    .enter   (cn_enter),
    .clear   (flush),
    .done    (cn_done),
    .start   (cn_start),
    .done_ok (cn_ok)
  );

  decoder_iter_ctrl_stage_handshake u_out_hs (
    .clk     (clk),
    .rst     (rst),
    .enter   (out_enter),
    .clear   (flush),
    .done    (out_done),
    .start   (out_start),
    .done_ok (out_ok)
  );

  // Next-state, iteration counter and stage-entry strobes; flush overrides all
  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    et_d      = et_q;
    vn_enter  = 1'b0;
    cn_enter  = 1'b0;
    out_enter = 1'b0;
    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            state_d  = StVnRun;
            vn_enter = 1'b1;
            iter_d   = '0;
            et_d     = 1'b0;
          end
        end
        StVnRun: begin
          if (vn_ok) begin
            state_d  = StCnRun;
            cn_enter = 1'b1;
          end
        end
        StCnRun: begin
          if (cn_ok) begin
            iter_d = iter_inc;
            if ((iter_inc == NIterCnt) || term_now) begin
              state_d   = StOutRun;
              out_enter = 1'b1;
              et_d      = term_now && (iter_inc < NIterCnt);
            end else begin
              state_d  = StVnRun;
              vn_enter = 1'b1;
            end
          end
        end
        StOutRun: begin
          if (out_ok) begin
            state_d = StOutHold;
          end
        end
        StOutHold: begin
          // dec_valid is always high in this state
          if (dec_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and registered outputs derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst == ResetVal) begin
      state_q     <= StIdle;
      iter_q      <= '0;
      et_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      dec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      et_q        <= et_d;
      in_ready_q  <= (state_d == StIdle);
      dec_valid_q <= (state_d == StOutHold);
    end
  end

endmodule

// File: doc/decoder_iter_ctrl.md
Name: decoder_iter_ctrl

Overview:
- Iteration scheduler for the min-sum decoder core.
- Sits between the LLR loader, which hands over a fully loaded frame, and the variable-node, check-node and output layers.
- Grants the frame, then sequences N_ITER rounds of VN->CN processing with start/done pulse handshakes.
- Triggers the output (hard-decision) layer and holds the result until downstream accepts it.

Parameters:
- N_ITER, 5, number of full VN+CN iterations per frame; legal range 1..2^ITER_W-1 (simulation-time check).
- ITER_W, 4, width of the iteration counter and iter_cnt output.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  loader has a complete frame in all_llrs
- in_ready  out  1  controller idle, frame can be taken
- flush  in  1  synchronous abort of current frame
- vn_start  out  1  one-cycle pulse: start variable-node pass
- vn_done  in  1  one-cycle pulse: VN pass complete
- cn_start  out  1  one-cycle pulse: start check-node pass
- cn_done  in  1  one-cycle pulse: CN pass complete
- syndrome_ok  in  1  all parity checks satisfied; qualified by cn_done
- out_start  out  1  one-cycle pulse: start output layer
- out_done  in  1  one-cycle pulse: dw_out valid from output layer
- dec_valid  out  1  decoded word available downstream
- dec_ready  in  1  downstream accepts decoded word
- iter_cnt  out  ITER_W  completed iterations of current/last frame
- early_term  out  1  last frame ended before N_ITER

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, in_ready=1, vn_start=cn_start=out_start=0, dec_valid=0, iter_cnt=0, early_term=0.
- States:
  - IDLE: in_ready=1.
  - VN_RUN: waits for vn_done.
  - CN_RUN: waits for cn_done.
  - OUT_RUN: waits for out_done.
  - OUT_HOLD: dec_valid=1.
- Accept: in_valid&in_ready at edge T -> state VN_RUN at T+1. At T+1: vn_start=1 for exactly that cycle, in_ready=0, iter_cnt=0, early_term=0.
- Entering any *_RUN state pulses its start output in the first cycle of that state only.
- *_done is sampled from the cycle after the start pulse. A done coincident with its own start pulse, or arriving in any other state, is ignored.
- vn_done in VN_RUN -> CN_RUN next cycle, with cn_start pulse.
- cn_done in CN_RUN -> iter_cnt+1 on the same edge. Next state:
  - OUT_RUN if the new iter_cnt == N_ITER;
  - VN_RUN otherwise, with vn_start pulse.
- out_done in OUT_RUN -> OUT_HOLD; dec_valid=1 from the next cycle.
- OUT_HOLD: dec_valid stays high until dec_valid&dec_ready. Then IDLE next cycle, with in_ready=1 and dec_valid=0.
- No back-to-back accept in the handoff cycle; minimum 1 IDLE cycle per frame.
- iter_cnt and early_term hold their final values through OUT_HOLD and IDLE until the next accept.
- Minimum latency with done pulses returned one cycle after start: accept -> dec_valid = 4*N_ITER + 3 cycles.
- flush: highest priority after rst. From any state -> IDLE next cycle; all pulses and dec_valid are cleared, iter_cnt is kept. flush in IDLE is a no-op, and in_valid in that same cycle is not accepted.
- rst mid-operation: immediate return to reset values; pending done pulses are lost, and the datapath is reset by the same rst.
- Counter never wraps; N_ITER < 2^ITER_W is enforced by parameter check.

Optional Feature:
- Macro: DECODER_EARLY_TERM_EN.
- Defined: syndrome_ok=1 together with cn_done in CN_RUN -> OUT_RUN regardless of iter_cnt. iter_cnt still increments on that edge; early_term=1 if the new iter_cnt < N_ITER.
- Undefined: syndrome_ok is ignored (port kept, unconnected internally), early_term is tied 0, and exactly N_ITER iterations always run.

Decomposition:
- Shared header (alongside ct.vh) holds:
  - state encodings IDLE/VN_RUN/CN_RUN/OUT_RUN/OUT_HOLD as 3-bit localparams;
  - the RESET_VAL used for the active-high reset;
  - default N_ITER/ITER_W.
- One natural sub-module, stage_handshake, instantiated three times (VN, CN, OUT). Each instance:
  - takes an enter strobe and generates the registered start pulse;
  - arms after the pulse and produces a qualified done.

Test Plan:
- Nominal, N_ITER=5, done pulses 1 cycle after each start -> 5 vn_start, 5 cn_start, 1 out_start; iter_cnt=5; dec_valid rises 23 cycles after accept; early_term=0.
- Backpressure: dec_ready low 10 cycles after dec_valid -> dec_valid held 10 cycles with in_ready=0; in_valid held high is accepted only after the IDLE cycle.
- Spurious done: vn_done in IDLE and cn_done during VN_RUN -> no state change, no start pulses, iter_cnt unchanged.
- Flush in CN_RUN at iteration 3 -> IDLE next cycle, in_ready=1, iter_cnt=2, no out_start; next frame starts with iter_cnt=0.
- Async rst asserted mid-OUT_RUN, between edges -> outputs at reset values immediately; after release, in_ready=1.
- DECODER_EARLY_TERM_EN defined, syndrome_ok=1 with 2nd cn_done -> out_start follows, iter_cnt=2, early_term=1. Same stimulus without the macro -> 5 iterations, early_term=0.
